// File: rtl/dac_tx_pkg.sv
// Shared types and constants for the dac_tx DAC sample streamer.
package dac_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRIME    = 2'd1,
    ST_RUN      = 2'd2,
    ST_UNDERRUN = 2'd3
  } state_e;

  localparam int DIV_W      = 16;
  localparam int URUN_CNT_W = 16;

  // Offset-binary zero code: MSB set, all lower bits clear (valid for widths up to 32).
  function automatic logic [31:0] midscale(input int unsigned data_w);
    return 32'd1 << (data_w - 1);
  endfunction

endpackage

// File: rtl/dac_tx_fifo.sv
// Single-clock sample FIFO with synchronous flush and occupancy output.
// Push and pop may occur together; a word pushed into an empty FIFO is not readable until the next cycle.
module dac_tx_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign level_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/dac_tx.sv
// Paced DAC sample streamer: buffers samples, primes the FIFO, then emits one code per div+1 cycles.
// Optional macro DAC_TX_TWOS_COMP_EN: input samples are two's complement and converted to offset binary.
module dac_tx
  import dac_tx_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int PRIME_LVL  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [DIV_W-1:0]              div,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          dac_clk,
  output logic [DATA_W-1:0]             dac_data,
  output logic                          underrun,
  output logic [URUN_CNT_W-1:0]         underrun_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int                 LVL_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0]   PRIME_CNT = LVL_W'(PRIME_LVL);
  localparam logic [DATA_W-1:0]  MIDSCALE  = DATA_W'(midscale(DATA_W));

  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]        div_lat_q, div_lat_d;
  logic [DATA_W-1:0]       dac_q, dac_d;
  logic [URUN_CNT_W-1:0]   underrun_cnt_q, underrun_cnt_d;

  logic                    fifo_flush, fifo_push, fifo_pop;
  logic                    fifo_full, fifo_empty;
  logic [DATA_W-1:0]       fifo_rd_data;
  logic [DATA_W-1:0]       rd_code;
  logic [LVL_W-1:0]        level;
  logic                    strobe;

  dac_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (fifo_flush),
    .push_i    (fifo_push),
    .wr_data_i (s_data),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level)
  );

`ifdef DAC_TX_TWOS_COMP_EN
  assign rd_code = {~fifo_rd_data[DATA_W-1], fifo_rd_data[DATA_W-2:0]};
`else
  assign rd_code = fifo_rd_data;
`endif

  // Sample tick; the period latched at the previous wrap keeps mid-run div changes glitch-free.
  assign strobe     = en && (state_q == ST_RUN) && (div_cnt_q == div_lat_q);
  assign fifo_pop   = strobe && !fifo_empty;
  assign underrun   = strobe && fifo_empty;
  assign fifo_flush = !en || (state_q == ST_IDLE);
  assign s_ready    = (state_q != ST_IDLE) && !fifo_full;
  assign fifo_push  = s_valid && s_ready;

  assign dac_clk      = ~clk;
  assign dac_data     = dac_q;
  assign underrun_cnt = underrun_cnt_q;
  assign fifo_level   = level;

  always_comb begin
    div_lat_d = div_lat_q;
    div_cnt_d = '0;
    if (state_q != ST_RUN || strobe) div_lat_d = div;
    if (en && state_q == ST_RUN && !strobe) div_cnt_d = div_cnt_q + 16'd1;
  end

  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (underrun && underrun_cnt_q != '1) underrun_cnt_d = underrun_cnt_q + 16'd1;
  end

  always_comb begin
    state_d = state_q;
    dac_d   = dac_q;
    if (!en) begin
      state_d = ST_IDLE;
      dac_d   = MIDSCALE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_PRIME;
          dac_d   = MIDSCALE;
        end
        ST_PRIME: begin
          dac_d = MIDSCALE;
          if (level >= PRIME_CNT) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (strobe) begin
            if (fifo_empty) begin
              state_d = ST_UNDERRUN;
              dac_d   = MIDSCALE;
            end else begin
              dac_d = rd_code;
            end
          end
        end
        ST_UNDERRUN: begin
          state_d = ST_PRIME;
          dac_d   = MIDSCALE;
        end
        default: begin
          state_d = ST_IDLE;
          dac_d   = MIDSCALE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      div_cnt_q      <= '0;
      div_lat_q      <= '0;
      dac_q          <= MIDSCALE;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      div_cnt_q      <= div_cnt_d;
      div_lat_q      <= div_lat_d;
      dac_q          <= dac_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

endmodule
